// File: rtl/mc_mainfsm_pkg.sv
// Shared types and encodings for the multicycle main control FSM.
//   state_e : 4-bit state codes (also exported on the State debug port)
//   ctrl_t  : control vector produced by the state decoder
package mc_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_EXECUTEM = 4'd10,
        S_MULWB    = 4'd11,
        S_FPUEXEC  = 4'd12,
        S_FPUWB    = 4'd13
    } state_e;

    localparam logic [1:0] SRCA_A        = 2'b00;
    localparam logic [1:0] SRCA_PC       = 2'b01;

    localparam logic [1:0] SRCB_WD       = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] MUL_PATTERN = 4'b1001;

    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
        logic       mul_op;
        logic       long_mul;
        logic       reg_src_mul;
        logic       fpu_w;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_mainfsm_if.sv
// Instruction-field inputs and control outputs between the main FSM and the
// multicycle datapath.
//   slave  : FSM side (reads Op/Funct/MulBits, drives controls and State)
//   master : datapath side
interface mc_mainfsm_if;
    import mc_ctrl_pkg::*;

    logic [1:0]         Op;
    logic [5:0]         Funct;
    logic [3:0]         MulBits;
    logic               IRWrite;
    logic               AdrSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ResultSrc;
    logic               NextPC;
    logic               RegW;
    logic               MemW;
    logic               Branch;
    logic               ALUOp;
    logic               MulOp;
    logic               Long;
    logic               RegSrcMul;
    logic               FpuW;
    logic               InstrDone;
    logic [STATE_W-1:0] State;

    modport slave (
        input  Op, Funct, MulBits,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW,
               Branch, ALUOp, MulOp, Long, RegSrcMul, FpuW, InstrDone, State
    );

    modport master (
        output Op, Funct, MulBits,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW,
               Branch, ALUOp, MulOp, Long, RegSrcMul, FpuW, InstrDone, State
    );

endinterface

// File: rtl/mc_mainfsm_outdec.sv
// Moore output decoder: state code -> datapath control vector.
//   state   : current FSM state
//   funct3  : Funct[3], selects the long-multiply dual write in MULWB
//   ctrl_c  : combinational control vector (all zero for unused codes)
module mc_mainfsm_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e state,
    input  logic   funct3,
    output ctrl_t  ctrl_c
);

    always_comb begin
        ctrl_c = '0;
        unique case (state)
            S_FETCH: begin
                ctrl_c.ir_write   = 1'b1;
                ctrl_c.alu_src_a  = SRCA_PC;
                ctrl_c.alu_src_b  = SRCB_FOUR;
                ctrl_c.result_src = RES_ALURESULT;
                ctrl_c.next_pc    = 1'b1;
            end
            S_DECODE: begin
                ctrl_c.alu_src_a  = SRCA_PC;
                ctrl_c.alu_src_b  = SRCB_FOUR;
                ctrl_c.result_src = RES_ALURESULT;
            end
            S_MEMADR: ctrl_c.alu_src_b = SRCB_IMM;
            S_MEMREAD: begin
                ctrl_c.adr_src    = 1'b1;
                ctrl_c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl_c.result_src = RES_DATA;
                ctrl_c.reg_w      = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_c.adr_src    = 1'b1;
                ctrl_c.result_src = RES_ALUOUT;
                ctrl_c.mem_w      = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_EXECUTER: begin
                ctrl_c.alu_src_b = SRCB_WD;
                ctrl_c.alu_op    = 1'b1;
            end
            S_EXECUTEI: begin
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = 1'b1;
            end
            S_ALUWB: begin
                ctrl_c.result_src = RES_ALUOUT;
                ctrl_c.reg_w      = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_b  = SRCB_IMM;
                ctrl_c.result_src = RES_ALURESULT;
                ctrl_c.branch     = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_EXECUTEM: begin
                ctrl_c.alu_op      = 1'b1;
                ctrl_c.mul_op      = 1'b1;
                ctrl_c.reg_src_mul = 1'b1;
            end
            S_MULWB: begin
                ctrl_c.result_src  = RES_ALUOUT;
                ctrl_c.reg_w       = 1'b1;
                ctrl_c.mul_op      = 1'b1;
                ctrl_c.reg_src_mul = 1'b1;
                ctrl_c.long_mul    = funct3;
                ctrl_c.instr_done  = 1'b1;
            end
            S_FPUEXEC: ctrl_c = '0;
            S_FPUWB: begin
                ctrl_c.fpu_w      = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            default: ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/mc_mainfsm.sv
// Multicycle main control FSM: sequences the unconditioned datapath controls
// for data-processing, multiply, load/store, branch and FPU instructions.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (returns to FETCH, clears FPU counter)
//   bus   : instruction fields in, control vector and debug State out
// FPU_LAT (1..15) sets the number of cycles spent in FPUEXEC.
module mc_mainfsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned FPU_LAT = 1
)(
    input  logic         clk,
    input  logic         reset,
    mc_mainfsm_if.slave  bus
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    ctrl_t            ctrl_c;
    logic             funct_unused;

    // Only Funct[5], Funct[3] and Funct[0] steer this block.
    assign funct_unused = ^{bus.Funct[4], bus.Funct[2:1]};

    // State register and FPU latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d = S_FETCH;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (bus.Op == OP_DP && !bus.Funct[5] && bus.MulBits == MUL_PATTERN) begin
                    state_d = S_EXECUTEM;
                end else if (bus.Op == OP_DP && bus.Funct[5]) begin
                    state_d = S_EXECUTEI;
                end else if (bus.Op == OP_DP) begin
                    state_d = S_EXECUTER;
                end else if (bus.Op == OP_MEM) begin
                    state_d = S_MEMADR;
                end else if (bus.Op == OP_BR) begin
                    state_d = S_BRANCH;
                end else begin
                    // Preload so the dwell in FPUEXEC is exactly FPU_LAT cycles.
                    state_d = S_FPUEXEC;
                    cnt_d   = CNT_W'(FPU_LAT - 1);
                end
            end
            S_MEMADR:   state_d = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_EXECUTEM: state_d = S_MULWB;
            S_MULWB:    state_d = S_FETCH;
            S_FPUEXEC: begin
                if (cnt_q != '0) begin
                    state_d = S_FPUEXEC;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_FPUWB;
                end
            end
            S_FPUWB:    state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode.
    mc_mainfsm_outdec u_outdec (
        .state  (state_q),
        .funct3 (bus.Funct[3]),
        .ctrl_c (ctrl_c)
    );

    assign bus.IRWrite   = ctrl_c.ir_write;
    assign bus.AdrSrc    = ctrl_c.adr_src;
    assign bus.ALUSrcA   = ctrl_c.alu_src_a;
    assign bus.ALUSrcB   = ctrl_c.alu_src_b;
    assign bus.ResultSrc = ctrl_c.result_src;
    assign bus.NextPC    = ctrl_c.next_pc;
    assign bus.RegW      = ctrl_c.reg_w;
    assign bus.MemW      = ctrl_c.mem_w;
    assign bus.Branch    = ctrl_c.branch;
    assign bus.ALUOp     = ctrl_c.alu_op;
    assign bus.MulOp     = ctrl_c.mul_op;
    assign bus.Long      = ctrl_c.long_mul;
    assign bus.RegSrcMul = ctrl_c.reg_src_mul;
    assign bus.FpuW      = ctrl_c.fpu_w;
    assign bus.InstrDone = ctrl_c.instr_done;
    assign bus.State     = state_q;

endmodule

// File: tb/tb_mc_mainfsm.sv
// Self-checking bench for mc_mainfsm: two instances (FPU_LAT=1 and 3), a
// directed instruction table, a mid-instruction reset sequence and random
// instructions checked cycle by cycle against a sequence-level model.
module tb_mc_mainfsm;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4;
    localparam int MEMWRITE = 5, EXECUTER = 6, EXECUTEI = 7, ALUWB = 8, BRANCH = 9;
    localparam int EXECUTEM = 10, MULWB = 11, FPUEXEC = 12, FPUWB = 13;

    typedef struct packed {
        logic [3:0] st;
        logic       irw, adr;
        logic [1:0] sa, sb, rs;
        logic       npc, regw, memw, br, aluop, mulop, lng, rsm, fpuw, done;
    } obs_t;

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] mb;
        int         dut;
        int         len;
        int         last_st;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   done_cyc;
    int   seq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mc_mainfsm_if if_a();
    mc_mainfsm_if if_b();

    mc_mainfsm #(.FPU_LAT(1)) dut_a (.clk(clk), .reset(rst_a), .bus(if_a.slave));
    mc_mainfsm #(.FPU_LAT(3)) dut_b (.clk(clk), .reset(rst_b), .bus(if_b.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t sample(input int d);
        obs_t o;
        if (d == 0) begin
            o = '{st: if_a.State, irw: if_a.IRWrite, adr: if_a.AdrSrc, sa: if_a.ALUSrcA,
                  sb: if_a.ALUSrcB, rs: if_a.ResultSrc, npc: if_a.NextPC, regw: if_a.RegW,
                  memw: if_a.MemW, br: if_a.Branch, aluop: if_a.ALUOp, mulop: if_a.MulOp,
                  lng: if_a.Long, rsm: if_a.RegSrcMul, fpuw: if_a.FpuW, done: if_a.InstrDone};
        end else begin
            o = '{st: if_b.State, irw: if_b.IRWrite, adr: if_b.AdrSrc, sa: if_b.ALUSrcA,
                  sb: if_b.ALUSrcB, rs: if_b.ResultSrc, npc: if_b.NextPC, regw: if_b.RegW,
                  memw: if_b.MemW, br: if_b.Branch, aluop: if_b.ALUOp, mulop: if_b.MulOp,
                  lng: if_b.Long, rsm: if_b.RegSrcMul, fpuw: if_b.FpuW, done: if_b.InstrDone};
        end
        return o;
    endfunction

    // Output table straight from the state descriptions; anything unlisted is 0.
    function automatic obs_t expect_of(input int st, input logic f3);
        obs_t e = '0;
        e.st = 4'(st);
        case (st)
            FETCH:    begin e.irw = 1; e.sa = 2'b01; e.sb = 2'b10; e.rs = 2'b10; e.npc = 1; end
            DECODE:   begin e.sa = 2'b01; e.sb = 2'b10; e.rs = 2'b10; end
            MEMADR:   e.sb = 2'b01;
            MEMREAD:  e.adr = 1;
            MEMWB:    begin e.rs = 2'b01; e.regw = 1; e.done = 1; end
            MEMWRITE: begin e.adr = 1; e.memw = 1; e.done = 1; end
            EXECUTER: e.aluop = 1;
            EXECUTEI: begin e.sb = 2'b01; e.aluop = 1; end
            ALUWB:    begin e.regw = 1; e.done = 1; end
            BRANCH:   begin e.sb = 2'b01; e.rs = 2'b10; e.br = 1; e.done = 1; end
            EXECUTEM: begin e.aluop = 1; e.mulop = 1; e.rsm = 1; end
            MULWB:    begin e.regw = 1; e.mulop = 1; e.rsm = 1; e.lng = f3; e.done = 1; end
            FPUWB:    begin e.fpuw = 1; e.done = 1; end
            default:  e = e;
        endcase
        return e;
    endfunction

    // Whole-instruction state trace derived from the instruction class.
    task automatic build_seq(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] mb,
                             input int lat);
        seq.delete();
        seq.push_back(FETCH);
        seq.push_back(DECODE);
        if (op == 2'b00 && !fn[5] && mb == 4'b1001) begin
            seq.push_back(EXECUTEM); seq.push_back(MULWB);
        end else if (op == 2'b00) begin
            seq.push_back(fn[5] ? EXECUTEI : EXECUTER); seq.push_back(ALUWB);
        end else if (op == 2'b01) begin
            seq.push_back(MEMADR);
            if (fn[0]) begin seq.push_back(MEMREAD); seq.push_back(MEMWB); end
            else seq.push_back(MEMWRITE);
        end else if (op == 2'b10) begin
            seq.push_back(BRANCH);
        end else begin
            for (int k = 0; k < lat; k++) seq.push_back(FPUEXEC);
            seq.push_back(FPUWB);
        end
    endtask

    task automatic drive(input int d, input logic [1:0] op, input logic [5:0] fn,
                         input logic [3:0] mb);
        if (d == 0) begin if_a.Op = op; if_a.Funct = fn; if_a.MulBits = mb; end
        else        begin if_b.Op = op; if_b.Funct = fn; if_b.MulBits = mb; end
    endtask

    // Called at a negedge with the selected DUT in FETCH; returns at a negedge
    // with it back in FETCH.
    task automatic run_instr(input int d, input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] mb, input string tag,
                             output int done_at, output int last_st);
        obs_t o, e;
        build_seq(op, fn, mb, (d == 0) ? 1 : 3);
        drive(d, op, fn, mb);
        done_at = -1;
        last_st = -1;
        for (int i = 0; i < seq.size(); i++) begin
            if (i > 0) @(negedge clk);
            #1;
            o = sample(d);
            e = expect_of(seq[i], fn[3]);
            check($sformatf("%s cyc%0d", tag, i + 1), 32'(o), 32'(e));
            check($sformatf("%s cyc%0d strobe-excl", tag, i + 1),
                  32'($countones({o.regw, o.memw, o.br, o.fpuw}) <= 1), 32'd1);
            if (o.done && done_at < 0) begin
                done_at  = i + 1;
                done_cyc = cyc;
            end
            last_st = int'(o.st);
        end
        @(negedge clk);
    endtask

    task automatic select_dut(input int d);
        if (d == 0) begin rst_b = 1'b0; rst_a = 1'b1; end
        else        begin rst_a = 1'b0; rst_b = 1'b1; end
    endtask

    vec_t vt[13];
    obs_t o;
    int   done_at, last_st, prev_dut, prev_done;

    initial begin
        vt[0]  = '{2'b00, 6'b000100, 4'b0000, 0, 4, ALUWB};
        vt[1]  = '{2'b00, 6'b101000, 4'b0000, 0, 4, ALUWB};
        vt[2]  = '{2'b00, 6'b101000, 4'b1001, 0, 4, ALUWB};
        vt[3]  = '{2'b00, 6'b000100, 4'b1011, 0, 4, ALUWB};
        vt[4]  = '{2'b01, 6'b011001, 4'b0000, 0, 5, MEMWB};
        vt[5]  = '{2'b01, 6'b011000, 4'b0000, 0, 4, MEMWRITE};
        vt[6]  = '{2'b00, 6'b001000, 4'b1001, 0, 4, MULWB};
        vt[7]  = '{2'b00, 6'b000000, 4'b1001, 0, 4, MULWB};
        vt[8]  = '{2'b10, 6'b101000, 4'b0000, 0, 3, BRANCH};
        vt[9]  = '{2'b11, 6'b000000, 4'b0000, 0, 4, FPUWB};
        vt[10] = '{2'b11, 6'b000001, 4'b0000, 1, 6, FPUWB};
        vt[11] = '{2'b10, 6'b000000, 4'b0000, 1, 3, BRANCH};
        vt[12] = '{2'b11, 6'b111111, 4'b1001, 1, 6, FPUWB};

        rst_a = 1'b0;
        rst_b = 1'b0;
        drive(0, 2'b00, 6'b0, 4'b0);
        drive(1, 2'b00, 6'b0, 4'b0);
        repeat (2) @(negedge clk);
        #1;
        check("reset A", 32'(sample(0)), 32'(expect_of(FETCH, 1'b0)));
        check("reset B", 32'(sample(1)), 32'(expect_of(FETCH, 1'b0)));

        // Reset dropped in the middle of a store.
        @(negedge clk);
        rst_a = 1'b1;
        drive(0, 2'b01, 6'b011000, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
        end
        o = sample(0);
        check("str memwrite state", 32'(o.st), 32'(MEMWRITE));
        check("str memwrite memw", 32'(o.memw), 32'd1);
        #2 rst_a = 1'b0;
        #1;
        check("async reset mid-store", 32'(sample(0)), 32'(expect_of(FETCH, 1'b0)));
        @(negedge clk);
        #1;
        check("reset held", 32'(sample(0)), 32'(expect_of(FETCH, 1'b0)));
        @(negedge clk);
        rst_a = 1'b1;
        run_instr(0, 2'b00, 6'b000100, 4'b0000, "post-reset add", done_at, last_st);
        check("post-reset add len", 32'(done_at), 32'd4);

        // Directed table; consecutive entries on the same DUT run back to back.
        prev_dut  = 0;
        prev_done = done_cyc;
        for (int v = 0; v < 13; v++) begin
            if (vt[v].dut != prev_dut) select_dut(vt[v].dut);
            run_instr(vt[v].dut, vt[v].op, vt[v].fn, vt[v].mb, $sformatf("vec%0d", v),
                      done_at, last_st);
            check($sformatf("vec%0d done cycle", v), 32'(done_at), 32'(vt[v].len));
            check($sformatf("vec%0d last state", v), 32'(last_st), 32'(vt[v].last_st));
            if (vt[v].dut == prev_dut)
                check($sformatf("vec%0d done spacing", v), 32'(done_cyc - prev_done),
                      32'(vt[v].len));
            prev_dut  = vt[v].dut;
            prev_done = done_cyc;
        end

        // Random instructions on each instance.
        for (int d = 0; d < 2; d++) begin
            if (d != prev_dut) select_dut(d);
            prev_dut = d;
            for (int r = 0; r < 30; r++) begin
                logic [1:0] op;
                logic [5:0] fn;
                logic [3:0] mb;
                int         exp_len;
                op = 2'($urandom_range(0, 3));
                fn = 6'($urandom);
                mb = ($urandom_range(0, 1) == 1) ? 4'b1001 : 4'($urandom);
                build_seq(op, fn, mb, (d == 0) ? 1 : 3);
                exp_len = seq.size();
                run_instr(d, op, fn, mb, $sformatf("rand d%0d #%0d", d, r), done_at, last_st);
                check($sformatf("rand d%0d #%0d len", d, r), 32'(done_at), 32'(exp_len));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
